// File: rtl/dds_pkg.sv
// Shared DDS definitions: table geometry, the signed sample type and the sine table generator.
// Everything here is elaboration-time; no clocked logic.
package dds_pkg;

    localparam int  DEF_ADDR_WIDTH = 10;
    localparam int  DEF_DATA_WIDTH = 32;
    localparam int  ROM_DEPTH      = 2 ** DEF_ADDR_WIDTH;
    localparam int  NUM_BANKS      = 8;
    localparam int  QW_BANKS       = 2;
    localparam real HALF_PI        = 1.5707963267948966;

    typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

    // Entry idx of a 2**aw-sample period scaled by 2**(dw-2), rounded to nearest.
    // Every entry is derived from its first-quadrant magnitude, so full and quarter-wave tables agree bit for bit.
    function automatic longint sine_entry(input int idx, input int aw, input int dw);
        int     n4;
        int     q;
        int     j;
        int     m;
        real    x;
        real    term;
        real    acc;
        real    amp;
        longint mag;
        n4   = 1 << (aw - 2);
        q    = (idx >> (aw - 2)) & 3;
        j    = idx & (n4 - 1);
        m    = ((q & 1) != 0) ? (n4 - j) : j;
        x    = HALF_PI * real'(m) / real'(n4);
        term = x;
        acc  = x;
        for (int k = 1; k < 16; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        amp = real'(longint'(1) << (dw - 2));
        mag = longint'($rtoi(acc * amp + 0.5));
        return (q >= 2) ? -mag : mag;
    endfunction

endpackage

// File: rtl/sine_bank_rom.sv
// One eighth of the sine period as a constant table with a registered read port; BANK picks the eighth.
// Latency 1 cycle; the read register holds its value while en is low.
module sine_bank_rom
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BANK       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [ADDR_WIDTH-4:0]        addr,
    output logic signed [DATA_WIDTH-1:0] dat
);

    localparam int DEPTH = (2 ** ADDR_WIDTH) / NUM_BANKS;

    logic signed [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        localparam longint VAL = sine_entry(BANK * DEPTH + k, ADDR_WIDTH, DATA_WIDTH);
        assign rom[k] = DATA_WIDTH'(VAL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dat <= '0;
        end else if (en) begin
            dat <= rom[addr];
        end
    end

endmodule

// File: rtl/sine_lut.sv
// Sine lookup: phase -> signed sample via S1 phase/decode, S2 banked ROM read, S3 sign/mirror fix-up (SINE_LUT_QUARTER_WAVE_EN stores quadrant 0 only).
// Latency 3 cycles from the accept cycle; one sample per clock when unstalled; bubbles pass through as invalid stages.
// Backpressure: all stages freeze together while the held sample is refused; phase_ready = !(sample_valid && !sample_ready).
module sine_lut
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        phase,
    input  logic                         phase_valid,
    output logic                         phase_ready,
    output logic signed [DATA_WIDTH-1:0] sample,
    output logic                         sample_valid,
    input  logic                         sample_ready
);

    localparam int OFF_W = ADDR_WIDTH - 3;
`ifdef SINE_LUT_QUARTER_WAVE_EN
    localparam int NB = QW_BANKS;
`else
    localparam int NB = NUM_BANKS;
`endif
    localparam int SEL_W = $clog2(NB);
    localparam logic signed [DATA_WIDTH-1:0] PEAK = {2'b01, {(DATA_WIDTH-2){1'b0}}};

    logic                         adv;
    logic                         s1_vld;
    logic [ADDR_WIDTH-1:0]        s1_phase;
    logic [SEL_W-1:0]             rd_bank;
    logic [OFF_W-1:0]             rd_off;
    logic                         rd_neg;
    logic                         rd_peak;
    logic                         s2_vld;
    logic [SEL_W-1:0]             s2_bank;
    logic                         s2_neg;
    logic                         s2_peak;
    logic signed [DATA_WIDTH-1:0] bank_dat [NB];
    logic signed [DATA_WIDTH-1:0] mag;
    logic signed [DATA_WIDTH-1:0] fixed;

    // Only the output register can refuse; everything upstream moves in lockstep with it.
    assign adv         = !(sample_valid && !sample_ready);
    assign phase_ready = adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld   <= 1'b0;
            s1_phase <= '0;
        end else if (adv) begin
            s1_vld   <= phase_valid;
            s1_phase <= phase;
        end
    end

`ifdef SINE_LUT_QUARTER_WAVE_EN
    logic [ADDR_WIDTH-3:0] quad_pos;
    logic [ADDR_WIDTH-3:0] mirror_pos;

    // Odd quadrants read backwards: N4-j wraps to 0 at j==0, which is exactly the peak case.
    always_comb begin
        quad_pos   = s1_phase[ADDR_WIDTH-3:0];
        mirror_pos = s1_phase[ADDR_WIDTH-2] ? ((ADDR_WIDTH-2)'(0) - quad_pos) : quad_pos;
        rd_bank    = mirror_pos[ADDR_WIDTH-3];
        rd_off     = mirror_pos[OFF_W-1:0];
        rd_neg     = s1_phase[ADDR_WIDTH-1];
        rd_peak    = s1_phase[ADDR_WIDTH-2] && (quad_pos == '0);
    end
`else
    always_comb begin
        rd_bank = s1_phase[ADDR_WIDTH-1 -: 3];
        rd_off  = s1_phase[OFF_W-1:0];
        rd_neg  = 1'b0;
        rd_peak = 1'b0;
    end
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        sine_bank_rom #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .BANK       (b)
        ) u_rom (
            .clk   (clk),
            .reset (reset),
            .en    (adv),
            .addr  (rd_off),
            .dat   (bank_dat[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld  <= 1'b0;
            s2_bank <= '0;
            s2_neg  <= 1'b0;
            s2_peak <= 1'b0;
        end else if (adv) begin
            s2_vld  <= s1_vld;
            s2_bank <= rd_bank;
            s2_neg  <= rd_neg;
            s2_peak <= rd_peak;
        end
    end

    always_comb begin
        mag   = s2_peak ? PEAK : bank_dat[s2_bank];
        fixed = s2_neg ? -mag : mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_valid <= 1'b0;
            sample       <= '0;
        end else if (adv) begin
            sample_valid <= s2_vld;
            sample       <= fixed;
        end
    end

endmodule

// File: tb/tb_sine_lut.sv
// Directed bench for sine_lut (ADDR_WIDTH=10, DATA_WIDTH=32): known points, sweep, stall, reset, counter patterns, bubbles.
module tb_sine_lut;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  phase;
    logic        phase_valid;
    logic        phase_ready;
    sample_t     sample;
    logic        sample_valid;
    logic        sample_ready;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_out   = 0;
    int          run     = 0;
    int          max_run = 0;
    bit          chk_lat = 1'b1;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    sine_lut #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .phase_ready  (phase_ready),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int i);
        real v;
        int  r;
        v = $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(ROM_DEPTH)) * 1073741824.0;
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return 32'(r);
    endfunction

    // One cycle: drive at the falling edge, then score what the next rising edge will transfer.
    task automatic tick(input logic v, input logic [9:0] p, input logic rdy, input logic [31:0] e);
        logic [31:0] want;
        int          at;
        @(negedge clk);
        phase_valid  = v;
        phase        = p;
        sample_ready = rdy;
        #1;
        cyc++;
        if (sample_valid && sample_ready) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (sample_valid && sample_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_sample", 32'(sample_valid), 0);
            end else begin
                want = exp_q.pop_front();
                at   = acc_q.pop_front();
                check("sample", sample, want);
                if (chk_lat) check("latency", cyc - at, 3);
            end
        end
        if (v && phase_ready) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
    endtask

    initial begin
        int          base;
        int          nxt;
        logic        rdy;
        logic        v;
        logic [31:0] frozen;

        reset        = 1'b1;
        phase_valid  = 1'b0;
        phase        = '0;
        sample_ready = 1'b0;
        frozen       = '0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_vld", 32'(sample_valid), 0);
        check("rst_sample", sample, 0);
        check("rst_ready", 32'(phase_ready), 1);
        repeat (3) @(negedge clk);
        check("rst_ready_hold", 32'(phase_ready), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("ready_after_rst", 32'(phase_ready), 1);
        check("vld_after_rst", 32'(sample_valid), 0);

        // Known points
        base = n_out;
        tick(1'b1, 10'd0,   1'b1, 32'h0000_0000);
        tick(1'b1, 10'd128, 1'b1, 32'h2D41_3CCD);
        tick(1'b1, 10'd256, 1'b1, 32'h4000_0000);
        tick(1'b1, 10'd512, 1'b1, 32'h0000_0000);
        tick(1'b1, 10'd768, 1'b1, 32'hC000_0000);
        repeat (4) tick(1'b0, 10'd0, 1'b1, 32'h0);
        check("points_count", n_out - base, 5);
        check("points_idle", 32'(sample_valid), 0);

        // Full sweep with wrap back to 0
        base    = n_out;
        max_run = 0;
        for (int i = 0; i <= 1024; i++) tick(1'b1, 10'(i % 1024), 1'b1, model(i % 1024));
        repeat (4) tick(1'b0, 10'd0, 1'b1, 32'h0);
        check("sweep_count", n_out - base, 1025);
        check("sweep_run", max_run, 1025);

        // Output stall for 10 cycles mid-stream
        chk_lat = 1'b0;
        base    = n_out;
        nxt     = 100;
        for (int t = 0; t < 40; t++) begin
            rdy = (t < 6 || t >= 16);
            tick(nxt < 120, 10'(nxt), rdy, model(nxt));
            if (phase_valid && phase_ready) nxt++;
            if (t == 6) frozen = sample;
            if (!rdy) begin
                check("stall_ready", 32'(phase_ready), 0);
                check("stall_vld", 32'(sample_valid), 1);
                if (t > 6) check("stall_hold", sample, frozen);
            end
        end
        check("stall_count", n_out - base, 20);
        check("stall_drain", exp_q.size(), 0);
        chk_lat = 1'b1;

        // Reset with three samples in flight
        tick(1'b1, 10'd200, 1'b1, model(200));
        tick(1'b1, 10'd201, 1'b1, model(201));
        tick(1'b1, 10'd202, 1'b1, model(202));
        @(negedge clk);
        check("pre_rst_vld", 32'(sample_valid), 1);
        reset       = 1'b0;
        phase_valid = 1'b0;
        #1;
        check("mid_rst_vld", 32'(sample_valid), 0);
        check("mid_rst_sample", sample, 0);
        check("mid_rst_ready", 32'(phase_ready), 1);
        exp_q.delete();
        acc_q.delete();
        run = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(phase_ready), 1);
        check("post_rst_vld", 32'(sample_valid), 0);
        base = n_out;
        tick(1'b1, 10'd300, 1'b1, model(300));
        tick(1'b0, 10'd0, 1'b1, 32'h0);
        tick(1'b0, 10'd0, 1'b1, 32'h0);
        check("post_rst_early", n_out - base, 0);
        tick(1'b0, 10'd0, 1'b1, 32'h0);
        check("post_rst_first", n_out - base, 1);

        // Counter-style streams: up by 3 from 5 (wraps), then down by 3 from 10 (wraps)
        base = n_out;
        nxt  = 5;
        for (int t = 0; t < 400; t++) begin
            tick(1'b1, 10'(nxt), 1'b1, model(nxt));
            nxt = (nxt + 3) % 1024;
        end
        nxt = 10;
        for (int t = 0; t < 20; t++) begin
            tick(1'b1, 10'(nxt), 1'b1, model(nxt));
            nxt = (nxt + 1024 - 3) % 1024;
        end
        repeat (4) tick(1'b0, 10'd0, 1'b1, 32'h0);
        check("counter_count", n_out - base, 420);

        // Alternating valid: bubbles reappear three cycles later in the same places
        for (int t = 0; t < 12; t++) begin
            v = (t < 8) && (t % 2 == 0);
            tick(v, 10'(50 + t), 1'b1, model(50 + t));
            check("alt_vld", 32'(sample_valid), 32'((t >= 3) && (t - 3 < 8) && ((t - 3) % 2 == 0)));
        end
        check("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
